// File: rtl/teller_dispatch_if.sv
// Signal bundle between the teller dispatcher and its surroundings
// (queue counter, teller windows, display path).
interface teller_dispatch_if;
    logic [2:0] teller_en;
    logic [2:0] teller_done;
    logic       queue_empty;
    logic       min_tick;
    logic       serve;
    logic       call_valid;
    logic [1:0] call_teller;
    logic [3:0] call_number;
    logic [2:0] teller_busy;
    logic [1:0] busy_count;

    // master: the dispatcher itself; slave: queue counter, tellers and display
    modport master (
        input  teller_en, teller_done, queue_empty, min_tick,
        output serve, call_valid, call_teller, call_number, teller_busy, busy_count
    );
    modport slave (
        output teller_en, teller_done, queue_empty, min_tick,
        input  serve, call_valid, call_teller, call_number, teller_busy, busy_count
    );
endinterface

// File: rtl/teller_dispatch.sv
// Round-robin scheduler granting the head customer to a free teller, announcing the
// call and timing each teller's service period in time-unit ticks.
module teller_dispatch #(
    parameter int unsigned NUM_TELLERS   = 3,
    parameter int unsigned SERVICE_TICKS = 3,
    parameter int unsigned ANNOUNCE_CYC  = 4
) (
    input logic              clock,
    input logic              reset,
    teller_dispatch_if.master bus
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StGrant    = 2'd1;
    localparam logic [1:0] StAnnounce = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] busy_q, busy_d;
    logic [3:0] timer_q [NUM_TELLERS];
    logic [3:0] timer_d [NUM_TELLERS];
    logic       serve_q, serve_d;
    logic       call_valid_q, call_valid_d;
    logic [1:0] call_teller_q, call_teller_d;
    logic [3:0] call_number_q, call_number_d;
    logic [1:0] busy_count_q, busy_count_d;

    logic [2:0] eligible;
    logic       grant_found;
    logic [1:0] grant_idx;
    logic [1:0] cand;

    assign eligible = bus.teller_en & ~busy_q;

    // Search starts one past the last granted teller.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 1; k <= int'(NUM_TELLERS); k++) begin
            cand = 2'((int'(ptr_q) + k) % int'(NUM_TELLERS));
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        busy_d        = busy_q;
        serve_d       = 1'b0;
        call_valid_d  = call_valid_q;
        call_teller_d = call_teller_q;
        call_number_d = call_number_q;
        for (int i = 0; i < int'(NUM_TELLERS); i++) begin
            timer_d[i] = timer_q[i];
            // An early finish wins over a tick arriving in the same cycle.
            if (busy_q[i]) begin
                if (bus.teller_done[i]) begin
                    timer_d[i] = 4'd0;
                    busy_d[i]  = 1'b0;
                end else if (bus.min_tick && timer_q[i] != 4'd0) begin
                    timer_d[i] = timer_q[i] - 4'd1;
                    if (timer_q[i] == 4'd1) begin
                        busy_d[i] = 1'b0;
                    end
                end
            end
        end

        case (state_q)
            StIdle: begin
                if (!bus.queue_empty && grant_found) begin
                    state_d            = StGrant;
                    serve_d            = 1'b1;
                    busy_d[grant_idx]  = 1'b1;
                    timer_d[grant_idx] = 4'(SERVICE_TICKS);
                    call_teller_d      = grant_idx + 2'd1;
                    call_number_d      = (call_number_q == 4'd15) ? 4'd1 : call_number_q + 4'd1;
                    ptr_d              = grant_idx;
                end
            end
            StGrant: begin
                state_d      = StAnnounce;
                call_valid_d = 1'b1;
                cnt_d        = 4'(ANNOUNCE_CYC - 1);
            end
            StAnnounce: begin
                if (cnt_q == 4'd0) begin
                    state_d      = StIdle;
                    call_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_count_d = {1'b0, busy_d[0]} + {1'b0, busy_d[1]} + {1'b0, busy_d[2]};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            ptr_q         <= 2'(NUM_TELLERS - 1);
            busy_q        <= 3'b000;
            serve_q       <= 1'b0;
            call_valid_q  <= 1'b0;
            call_teller_q <= 2'd0;
            call_number_q <= 4'd0;
            busy_count_q  <= 2'd0;
            for (int i = 0; i < int'(NUM_TELLERS); i++) begin
                timer_q[i] <= 4'd0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            busy_q        <= busy_d;
            serve_q       <= serve_d;
            call_valid_q  <= call_valid_d;
            call_teller_q <= call_teller_d;
            call_number_q <= call_number_d;
            busy_count_q  <= busy_count_d;
            for (int i = 0; i < int'(NUM_TELLERS); i++) begin
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign bus.serve       = serve_q;
    assign bus.call_valid  = call_valid_q;
    assign bus.call_teller = call_teller_q;
    assign bus.call_number = call_number_q;
    assign bus.teller_busy = busy_q;
    assign bus.busy_count  = busy_count_q;

endmodule

// File: tb/tb_teller_dispatch.sv
// Randomized bench for teller_dispatch, compared every cycle against a
// grant-spacing / remaining-ticks model of the dispatcher.
module tb_teller_dispatch;

    localparam int unsigned SERVICE_TICKS = 3;
    localparam int unsigned ANNOUNCE_CYC  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    teller_dispatch_if bus ();

    teller_dispatch #(
        .NUM_TELLERS  (3),
        .SERVICE_TICKS(SERVICE_TICKS),
        .ANNOUNCE_CYC (ANNOUNCE_CYC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int serves_seen = 0;

    // Model: remaining service ticks per teller, last granted teller,
    // edges since the last grant and edges still blocked for granting.
    int m_rem [3];
    int m_last, m_num, m_teller, m_hold, m_since;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_rem[i] = 0;
        m_last   = 2;
        m_num    = 0;
        m_teller = 0;
        m_hold   = 0;
        m_since  = 100;
    endtask

    task automatic model_edge();
        logic [2:0] elig;
        int g;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) elig[i] = bus.teller_en[i] && (m_rem[i] == 0);
        for (int i = 0; i < 3; i++) begin
            if (m_rem[i] > 0) begin
                if (bus.teller_done[i]) m_rem[i] = 0;
                else if (bus.min_tick) m_rem[i] = m_rem[i] - 1;
            end
        end
        if (m_since < 100) m_since++;
        g = -1;
        if (m_hold > 0) begin
            m_hold--;
        end else if (!bus.queue_empty) begin
            for (int k = 1; k <= 3; k++) begin
                if (g < 0 && elig[(m_last + k) % 3]) g = (m_last + k) % 3;
            end
        end
        if (g >= 0) begin
            m_rem[g] = SERVICE_TICKS;
            m_last   = g;
            m_teller = g + 1;
            m_num    = (m_num % 15) + 1;
            m_hold   = ANNOUNCE_CYC + 1;
            m_since  = 0;
        end
    endtask

    task automatic compare_all();
        logic [2:0] exp_busy;
        int exp_cnt;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            exp_busy[i] = (m_rem[i] > 0);
            exp_cnt += (m_rem[i] > 0) ? 1 : 0;
        end
        check("serve", 32'(bus.serve), 32'(m_since == 0));
        check("call_valid", 32'(bus.call_valid),
              32'(m_since >= 1 && m_since <= int'(ANNOUNCE_CYC)));
        check("call_teller", 32'(bus.call_teller), 32'(m_teller));
        check("call_number", 32'(bus.call_number), 32'(m_num));
        check("teller_busy", 32'(bus.teller_busy), 32'(exp_busy));
        check("busy_count", 32'(bus.busy_count), 32'(exp_cnt));
        if (bus.serve === 1'b1) serves_seen++;
    endtask

    task automatic cycle(input logic [2:0] en, input logic [2:0] done, input logic qe,
                         input logic tick);
        bus.teller_en   = en;
        bus.teller_done = done;
        bus.queue_empty = qe;
        bus.min_tick    = tick;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all();
    endtask

    function automatic logic rnd_tick(input int odds);
        return ($urandom_range(0, odds - 1) == 0);
    endfunction

    function automatic logic [2:0] rnd_done();
        return ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
    endfunction

    initial begin
        int base;
        bit hit;
        model_reset();
        bus.teller_en   = 3'b111;
        bus.teller_done = 3'b000;
        bus.queue_empty = 1'b0;
        bus.min_tick    = 1'b0;

        // Reset held with a full queue and all tellers open.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(3'b111, 3'b000, 1'b0, rnd_tick(3));
        check("reset_no_serve", 32'(serves_seen), 32'd0);
        reset = 1'b1;

        // Single teller.
        for (int i = 0; i < 80; i++) cycle(3'b001, 3'b000, 1'b0, rnd_tick(4));

        // All tellers, round-robin with slow ticks so busy_count saturates.
        for (int i = 0; i < 100; i++) cycle(3'b111, 3'b000, 1'b0, rnd_tick(8));

        // Random early releases.
        for (int i = 0; i < 200; i++) cycle(3'($urandom_range(0, 7)), rnd_done(), 1'b0, rnd_tick(5));

        // Empty queue: no serves.
        base = serves_seen;
        for (int i = 0; i < 50; i++) cycle(3'b111, 3'b000, 1'b1, rnd_tick(4));
        check("empty_no_serve", 32'(serves_seen - base), 32'd0);

        // All tellers disabled: no serves; busy bits still drain.
        base = serves_seen;
        for (int i = 0; i < 50; i++) cycle(3'b000, 3'b000, 1'b0, rnd_tick(3));
        check("disabled_no_serve", 32'(serves_seen - base), 32'd0);

        // Fully random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(3'($urandom_range(0, 7)), rnd_done(), rnd_tick(4), rnd_tick(4));
        end

        // Ticket number wrap: fresh reset then at least 16 grants.
        reset = 1'b0;
        cycle(3'b111, 3'b000, 1'b0, 1'b0);
        reset = 1'b1;
        base = serves_seen;
        for (int i = 0; i < 110; i++) cycle(3'b111, 3'b000, 1'b0, 1'b1);
        check("wrap_grants", 32'(serves_seen - base >= 16), 32'd1);

        // Reset in the middle of an announcement.
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_since == 2) hit = 1'b1;
            else cycle(3'b111, 3'b000, 1'b0, 1'b1);
        end
        check("reach_announce", 32'(hit), 32'd1);
        reset = 1'b0;
        cycle(3'b111, 3'b000, 1'b0, 1'b1);
        check("mid_reset_valid", 32'(bus.call_valid), 32'd0);
        check("mid_reset_number", 32'(bus.call_number), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) cycle(3'b111, rnd_done(), 1'b0, rnd_tick(2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/teller_dispatch.md
Name: teller_dispatch

Overview:
- Scheduler between the customer queue counter and up to three teller windows.
- When the queue is non-empty and an enabled teller is free, it grants the head customer to one teller (round-robin) and pulses `serve` to decrement the queue count.
- It announces the call (teller number and ticket number) for the display path and times each teller's service period in time-unit ticks.
- It runs on the divided system clock alongside the queue counter.

Parameters:
- NUM_TELLERS, 3, number of teller windows; fixed at 3 for this design.
- SERVICE_TICKS, 3, time units a teller stays busy per customer (matches the 3-units-per-person wait estimate); range 1..15.
- ANNOUNCE_CYC, 4, clock cycles `call_valid` is held per call; range 1..15.

Ports:
- clock  in  1  divided system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- teller_en  in  3  per-teller enable; same encoding as Tcount (bit i = teller i+1 open).
- teller_done  in  3  per-teller "customer finished early" pulse; frees that teller.
- queue_empty  in  1  empty flag from the queue counter.
- min_tick  in  1  one-cycle time-unit strobe.
- serve  out  1  one-cycle pulse; queue counter decrements Pcount by 1.
- call_valid  out  1  high while a call is being announced.
- call_teller  out  2  teller being called, 1..3; 0 = none.
- call_number  out  4  ticket number of the current or last call, 1..15.
- teller_busy  out  3  per-teller busy status.
- busy_count  out  2  number of busy tellers, 0..3.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FSM goes to IDLE; all timers clear to 0.
  - Outputs: teller_busy=000, busy_count=0, serve=0, call_valid=0, call_teller=0, call_number=0.
  - The round-robin pointer is set so teller 1 has first priority.
  - Reset mid-call aborts the announcement. An in-flight serve pulse is not repeated.
- Eligibility: teller i is eligible when teller_en[i]=1 and teller_busy[i]=0, both as registered at the current edge.
- FSM states: IDLE, GRANT, ANNOUNCE.
- IDLE -> GRANT when queue_empty=0 and at least one teller is eligible; otherwise stay in IDLE.
- During the GRANT cycle (exactly one cycle):
  - serve=1.
  - The selected teller's busy bit is set and its timer is loaded with SERVICE_TICKS.
  - call_teller is set to the teller index+1.
  - call_number increments (15 wraps to 1; 0 is only ever the reset value).
  - The pointer is updated to the granted teller.
- GRANT -> ANNOUNCE.
- ANNOUNCE:
  - call_valid=1 for exactly ANNOUNCE_CYC cycles; call_teller and call_number are held; then -> IDLE.
  - No new grant is made during ANNOUNCE.
  - call_teller and call_number keep their last value in IDLE; call_valid=0.
- Latency and spacing: the first grant occurs 1 cycle after eligibility is seen in IDLE. Back-to-back grants are spaced ANNOUNCE_CYC+2 cycles apart.
- Round-robin: the search starts at pointer+1 (mod 3) and takes the first eligible teller. Teller 3 wraps to teller 1.
- Service timer:
  - Decrements by 1 on each min_tick while it is non-zero.
  - Reaching 0 clears the busy bit in the same edge.
  - A freed teller is eligible from the next cycle.
- teller_done[i] clears timer i and busy[i] at the next edge. It overrides min_tick in the same cycle. It is ignored if teller i is not busy.
- A grant and a teller_done for the same teller cannot coincide, because a granted teller was not busy.
- Disabling a busy teller (teller_en[i] 1->0): it finishes the current customer and is not granted again until re-enabled.
- All tellers disabled: no grants, even with queue_empty=0.
- queue_empty=1: no grant and no serve. queue_empty rising during ANNOUNCE has no effect on the current call.
- busy_count is the registered popcount of teller_busy, updated in the same cycle as teller_busy.

Test Plan:
- Reset: hold reset=0 for 3 cycles with queue_empty=0, teller_en=111 -> no serve; all outputs 0; call_teller=0.
- Single teller (teller_en=001, queue_empty=0), first grant:
  - serve pulses once; call_teller=1, call_number=1, call_valid high for 4 cycles.
  - No second serve until 3 min_ticks have elapsed.
  - Then serve again with call_number=2.
- Round-robin (teller_en=111, queue_empty=0) -> grants go to tellers 1, 2, 3, spaced 6 cycles apart; busy_count reaches 3; no 4th serve until a teller frees.
- Early release: teller 2 busy, pulse teller_done=010 together with min_tick -> teller_busy[1]=0 at the next edge; the next grant goes to teller 2 if it is the only eligible teller.
- Empty and disable: queue_empty=1 for 50 cycles -> zero serve pulses. Set teller_en=000 with queue_empty=0 -> zero serves. Clearing teller_en while tellers are busy -> the busy bits still drop after 3 ticks.
- Wrap: perform 16 grants -> call_number sequence 1..15 then 1. Asserting reset mid-ANNOUNCE -> call_valid=0 and call_number=0 on the next edge.
